oam_dma: RTL and testbench
==========================

# oam_dma

OAM DMA initiator for the NES core. Captures CPU writes to $4014 and takes over the CPU bus. Copies the 256-byte CPU page $XX00–$XXFF into sprite RAM by issuing 256 read/write pairs, each write targeting the PPU OAM data register $2004. It is the bus-master counterpart of the PPU's register-responder interface and drives the PPU's `dma_hijack` path.

## Interface
Parameters:
- `DMA_REG`, 16'h4014, CPU address that triggers a transfer
- `OAM_DATA_REG`, 16'h2004, PPU OAM data port address written per byte

Ports:
- `ppu_clk`  in  1  block clock
- `reset`  in  1  reset, synchronous, active-high; clock ppu_clk
- `cpu_ce`  in  1  one-`ppu_clk` pulse marking the end of each CPU cycle; all state advances gated by it
- `odd_or_even`  in  1  CPU cycle parity, 1 = current CPU cycle odd
- `bus_addr`  in  16  CPU bus address (snooped)
- `bus_din`  in  8  CPU write data (snooped)
- `bus_wr`  in  1  CPU write strobe (snooped)
- `mem_rdata`  in  8  CPU memory read data for `dma_addr`
- `dma_hijack`  out  1  CPU halted; bus mux selects DMA signals
- `dma_addr`  out  16  DMA-driven bus address
- `dma_wr`  out  1  DMA write strobe
- `dma_dout`  out  8  DMA write data
- `busy`  out  1  transfer in progress (equals `dma_hijack`)

## Operation
- Trigger: `cpu_ce & bus_wr & bus_addr==DMA_REG` while IDLE latches `page <= bus_din` and moves IDLE→HALT.
- Triggers while not IDLE are ignored.
- Writes to any other address never trigger.
- FSM states are IDLE, HALT, ALIGN, READ, WRITE. Transitions occur only on `ppu_clk` edges with `cpu_ce=1`:
  - HALT → ALIGN if `odd_or_even=1`, else → READ.
  - ALIGN → READ.
  - READ → WRITE, latching `data <= mem_rdata`.
  - WRITE → READ with `idx <= idx+1` if `idx != 8'hFF`; else → IDLE.
- `idx`: 8-bit byte index, cleared on trigger. Arithmetic is modulo 256. The transfer ends on the WRITE with `idx==8'hFF`, and `idx` wraps back to 0.
- Outputs are combinational from state and registers:
  - READ: `dma_addr={page,idx}`, `dma_wr=0`.
  - WRITE: `dma_addr=OAM_DATA_REG`, `dma_wr=1`, `dma_dout=data`.
  - HALT/ALIGN: `dma_addr={page,8'h00}`, `dma_wr=0`.
  - IDLE: `dma_addr=0`, `dma_wr=0`, `dma_dout=0`.
- `dma_hijack=busy=(state!=IDLE)`.
- Bytes go to $2004 in address order $XX00..$XXFF. The PPU's OAM_ADDR auto-behaviour is outside this block.
- Reset: state=IDLE, page=0, idx=0, data=0. All outputs are 0 on the cycle after reset is sampled, including mid-transfer. A partial transfer is abandoned, not resumed.
- `cpu_ce=0` cycles hold all state and outputs. Gaps of any length are tolerated.
- Page $20 or any other page is legal. No address filtering is applied on reads.

## Timing
- `dma_hijack` rises on the first `ppu_clk` edge after the trigger `cpu_ce`. It falls on the `ppu_clk` edge ending the final WRITE.
- Hijack length in CPU cycles (cpu_ce pulses while high): 513 if `odd_or_even=0` at HALT end, 514 if 1.
  - Breakdown: 1 HALT, 0/1 ALIGN, 256 READ, 256 WRITE.
- Read latency: `mem_rdata` must be valid at the `cpu_ce` edge ending READ, i.e. one CPU cycle after `dma_addr` is presented. Synchronous RAM on `ram_clk` meets this.
- `dma_wr` is high for exactly one full CPU cycle per byte. It is never high in consecutive CPU cycles.
- A trigger coincident with reset is ignored (reset wins).
- A trigger in the same cycle the FSM returns to IDLE is ignored. The state is not yet IDLE when sampled.

## Test plan
- Reset check: assert reset mid-idle, then release → `dma_hijack=0`, `dma_wr=0`, `dma_addr=0`, `dma_dout=0`. Write $4013=0x05 and $4015=0x05 → no hijack.
- Even-parity copy: preload $0200–$02FF with `i^8'hA5`; write $4014=0x02 with `odd_or_even=0` → hijack high for 513 `cpu_ce`. Exactly 256 writes to $2004 carry data `0xA5,0xA4,...` in order. Reads cover $0200..$02FF ascending.
- Odd-parity copy: same stimulus with `odd_or_even=1` at HALT → 514 `cpu_ce` hijack, with one extra idle cycle before the first READ. Data is identical.
- Clock-enable gaps: `cpu_ce` every 3rd `ppu_clk` with random extra gaps → same 513/514 pulse count and identical write sequence. Outputs are stable during gaps.
- Re-trigger and back-to-back:
  - Write $4014=0x03 during a transfer → ignored; the page stays 0x02.
  - After completion, write $4014=0x07 → a new transfer reads $0700–$07FF.
- Reset mid-transfer: assert reset after byte 100's WRITE → next cycle IDLE with outputs 0. A following $4014=0x02 write restarts from $0200.

Source files
------------

// File: rtl/oam_dma.sv
// OAM DMA initiator: snoops CPU writes to $4014, halts the CPU and copies one
// 256-byte page into sprite RAM through the PPU OAM data port.
module oam_dma #(
    parameter logic [15:0] DMA_REG      = 16'h4014,
    parameter logic [15:0] OAM_DATA_REG = 16'h2004
) (
    input  logic        ppu_clk,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic        odd_or_even,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_din,
    input  logic        bus_wr,
    input  logic [7:0]  mem_rdata,
    output logic        dma_hijack,
    output logic [15:0] dma_addr,
    output logic        dma_wr,
    output logic [7:0]  dma_dout,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;

    always_ff @(posedge ppu_clk) begin
        if (reset) begin
            state_q <= IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    // Everything advances only on the CPU-cycle strobe; cpu_ce=0 holds all state.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;
        if (cpu_ce) begin
            unique case (state_q)
                IDLE: begin
                    if (bus_wr && (bus_addr == DMA_REG)) begin
                        page_d  = bus_din;
                        idx_d   = 8'h00;
                        state_d = HALT;
                    end
                end
                HALT:  state_d = odd_or_even ? ALIGN : READ;
                ALIGN: state_d = READ;
                READ: begin
                    data_d  = mem_rdata;
                    state_d = WRITE;
                end
                WRITE: begin
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_q == 8'hFF) ? IDLE : READ;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        dma_addr = 16'h0000;
        dma_wr   = 1'b0;
        dma_dout = 8'h00;
        unique case (state_q)
            HALT, ALIGN: dma_addr = {page_q, 8'h00};
            READ:        dma_addr = {page_q, idx_q};
            WRITE: begin
                dma_addr = OAM_DATA_REG;
                dma_wr   = 1'b1;
                dma_dout = data_q;
            end
            default: ;
        endcase
    end

    assign dma_hijack = (state_q != IDLE);
    assign busy       = dma_hijack;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: a per-CPU-cycle position model predicts every output on
// every ppu_clk, with literal checks on transfer length and written data.
module tb_oam_dma;
    logic        ppu_clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_ce = 1'b0;
    logic        odd_or_even = 1'b0;
    logic [15:0] bus_addr = 16'h0000;
    logic [7:0]  bus_din = 8'h00;
    logic        bus_wr = 1'b0;
    logic [7:0]  mem_rdata;
    logic        dma_hijack;
    logic [15:0] dma_addr;
    logic        dma_wr;
    logic [7:0]  dma_dout;
    logic        busy;

    logic [7:0] mem [0:65535];
    assign mem_rdata = mem[dma_addr];

    oam_dma dut (
        .ppu_clk(ppu_clk), .reset(reset), .cpu_ce(cpu_ce), .odd_or_even(odd_or_even),
        .bus_addr(bus_addr), .bus_din(bus_din), .bus_wr(bus_wr), .mem_rdata(mem_rdata),
        .dma_hijack(dma_hijack), .dma_addr(dma_addr), .dma_wr(dma_wr),
        .dma_dout(dma_dout), .busy(busy)
    );

    always #5 ppu_clk = ~ppu_clk;

    int compared = 0;
    int mismatched = 0;
    int printed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            if (printed < 40) begin
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
                printed++;
            end
        end
    endtask

    // Model: a transfer is a run of CPU cycles numbered from 0 (halt);
    // length is 513 plus one alignment cycle when parity was odd at halt end.
    bit         m_busy = 1'b0;
    logic [7:0] m_page = 8'h00;
    int         m_pos = 0;
    bit         m_align = 1'b0;
    bit         started = 1'b0;

    initial begin
        forever begin
            @(posedge ppu_clk);
            started = 1'b1;
            if (reset) begin
                m_busy = 1'b0;
                m_page = 8'h00;
            end else if (cpu_ce) begin
                if (!m_busy) begin
                    if (bus_wr && bus_addr == 16'h4014) begin
                        m_busy  = 1'b1;
                        m_page  = bus_din;
                        m_pos   = 0;
                        m_align = 1'b0;
                    end
                end else begin
                    if (m_pos == 0) m_align = odd_or_even;
                    m_pos++;
                    if (m_pos == 513 + int'(m_align)) m_busy = 1'b0;
                end
            end
        end
    end

    int         hcnt = 0;
    logic [7:0] wq[$];

    initial begin
        forever begin
            logic        e_h, e_wr, chk_d;
            logic [15:0] e_addr;
            logic [7:0]  e_dout;
            int          o, b;
            @(negedge ppu_clk);
            if (started) begin
                e_h = 1'b0; e_wr = 1'b0; e_addr = 16'h0000; e_dout = 8'h00; chk_d = 1'b1;
                if (m_busy) begin
                    e_h = 1'b1;
                    chk_d = 1'b0;
                    if (m_pos == 0 || (m_align && m_pos == 1)) begin
                        e_addr = {m_page, 8'h00};
                    end else begin
                        o = m_pos - 1 - int'(m_align);
                        b = o / 2;
                        if (o % 2 == 0) begin
                            e_addr = {m_page, 8'(b)};
                        end else begin
                            e_addr = 16'h2004;
                            e_wr   = 1'b1;
                            e_dout = mem[{m_page, 8'(b)}];
                            chk_d  = 1'b1;
                        end
                    end
                end
                chk("hijack", {31'b0, dma_hijack}, {31'b0, e_h});
                chk("busy", {31'b0, busy}, {31'b0, e_h});
                chk("addr", {16'b0, dma_addr}, {16'b0, e_addr});
                chk("wr", {31'b0, dma_wr}, {31'b0, e_wr});
                if (chk_d) chk("dout", {24'b0, dma_dout}, {24'b0, e_dout});
                if (cpu_ce && dma_hijack) hcnt++;
                if (cpu_ce && dma_wr) wq.push_back(dma_dout);
            end
        end
    end

    bit gap_mode = 1'b0;
    int ph = 0;
    initial begin
        forever begin
            @(posedge ppu_clk);
            #1;
            if (gap_mode) begin
                if (ph >= 2 && $urandom_range(0, 3) != 0) begin
                    cpu_ce = 1'b1;
                    ph = 0;
                end else begin
                    cpu_ce = 1'b0;
                    ph++;
                end
            end else begin
                cpu_ce = 1'b1;
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        int n = 0;
        @(negedge ppu_clk);
        bus_addr = a; bus_din = d; bus_wr = 1'b1;
        do begin
            @(posedge ppu_clk);
            n++;
        end while (!cpu_ce && n < 100);
        @(negedge ppu_clk);
        bus_wr = 1'b0; bus_addr = 16'h0000;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_busy && n < 6000) begin
            @(negedge ppu_clk);
            #1;
            n++;
        end
        chk("idle_timeout", {31'b0, m_busy}, 32'd0);
    endtask

    task automatic run_copy(input logic [7:0] page, input logic par, input bit retrig);
        hcnt = 0;
        wq.delete();
        odd_or_even = par;
        cpu_write(16'h4014, page);
        if (retrig) begin
            repeat (60) @(negedge ppu_clk);
            cpu_write(16'h4014, 8'h03);
        end
        wait_idle();
        chk("hijack_len", hcnt, par ? 32'd514 : 32'd513);
        chk("write_count", wq.size(), 32'd256);
        if (wq.size() == 256) begin
            int bad = 0;
            for (int i = 0; i < 256; i++)
                if (wq[i] !== mem[{page, 8'(i)}]) bad++;
            chk("write_sequence_errors", bad, 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

        repeat (3) @(negedge ppu_clk);
        reset = 1'b0;
        repeat (4) @(negedge ppu_clk);
        reset = 1'b1;
        @(negedge ppu_clk);
        reset = 1'b0;
        @(negedge ppu_clk);
        chk("rst_hijack", {31'b0, dma_hijack}, 32'd0);
        chk("rst_wr", {31'b0, dma_wr}, 32'd0);
        chk("rst_addr", {16'b0, dma_addr}, 32'd0);
        chk("rst_dout", {24'b0, dma_dout}, 32'd0);

        cpu_write(16'h4013, 8'h05);
        cpu_write(16'h4015, 8'h05);
        repeat (3) @(negedge ppu_clk);
        chk("other_addr_no_hijack", {31'b0, dma_hijack}, 32'd0);

        run_copy(8'h02, 1'b0, 1'b1);
        if (wq.size() >= 256) begin
            chk("even_first_byte", {24'b0, wq[0]}, 32'hA5);
            chk("even_second_byte", {24'b0, wq[1]}, 32'hA4);
            chk("even_last_byte", {24'b0, wq[255]}, 32'h5A);
        end

        run_copy(8'h02, 1'b1, 1'b0);
        if (wq.size() >= 1) chk("odd_first_byte", {24'b0, wq[0]}, 32'hA5);

        gap_mode = 1'b1;
        run_copy(8'h02, 1'b0, 1'b0);
        run_copy(8'h02, 1'b1, 1'b0);
        gap_mode = 1'b0;
        repeat (4) @(negedge ppu_clk);

        for (int i = 0; i < 256; i++) mem[16'h0700 + i] = 8'($urandom);
        run_copy(8'h02, 1'b0, 1'b0);
        run_copy(8'h07, 1'($urandom_range(0, 1)), 1'b0);

        // Trigger landing on the very cycle the transfer ends must be ignored.
        hcnt = 0;
        wq.delete();
        odd_or_even = 1'b0;
        cpu_write(16'h4014, 8'h07);
        begin
            int n = 0;
            while (!(m_busy && m_pos == 512 + int'(m_align)) && n < 6000) begin
                @(negedge ppu_clk);
                #1;
                n++;
            end
            chk("end_wait_timeout", n, (n < 6000) ? n : 0);
        end
        bus_addr = 16'h4014; bus_din = 8'h09; bus_wr = 1'b1;
        @(posedge ppu_clk);
        @(negedge ppu_clk);
        bus_wr = 1'b0; bus_addr = 16'h0000;
        @(negedge ppu_clk);
        chk("end_coincident_trigger", {31'b0, dma_hijack}, 32'd0);
        chk("end_coincident_writes", wq.size(), 32'd256);

        // Trigger together with reset: reset wins.
        @(negedge ppu_clk);
        reset = 1'b1; bus_addr = 16'h4014; bus_din = 8'h02; bus_wr = 1'b1;
        @(negedge ppu_clk);
        reset = 1'b0; bus_wr = 1'b0; bus_addr = 16'h0000;
        @(negedge ppu_clk);
        chk("reset_trigger_ignored", {31'b0, dma_hijack}, 32'd0);

        // Reset mid-transfer, then a fresh transfer restarts at byte 0.
        hcnt = 0;
        wq.delete();
        cpu_write(16'h4014, 8'h02);
        begin
            int n = 0;
            while (wq.size() < 101 && n < 6000) begin
                @(negedge ppu_clk);
                #1;
                n++;
            end
            chk("byte100_seen", wq.size(), 32'd101);
        end
        @(posedge ppu_clk);
        @(negedge ppu_clk);
        reset = 1'b1;
        @(negedge ppu_clk);
        chk("midrst_hijack", {31'b0, dma_hijack}, 32'd0);
        chk("midrst_addr", {16'b0, dma_addr}, 32'd0);
        chk("midrst_wr", {31'b0, dma_wr}, 32'd0);
        chk("midrst_dout", {24'b0, dma_dout}, 32'd0);
        reset = 1'b0;
        run_copy(8'h02, 1'b0, 1'b0);
        if (wq.size() >= 1) chk("restart_first_byte", {24'b0, wq[0]}, 32'hA5);

        repeat (5) @(negedge ppu_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
